// File: rtl/sram_lane_ctrl.sv
// sram_lane_ctrl: lane-banked row memory with self-clear on reset/request
// and a fixed-latency read pipeline.
module sram_lane_ctrl #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 100,
  parameter int RD_LAT    = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int LANE_W   = DATA_W / NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_en,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    wr_data_in,
  input  logic [NUM_LANES-1:0] wr_lane_en,
  input  logic                 clear_req,
  output logic                 req_ready,
  output logic                 busy,
  output logic                 rd_data_val,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 err_addr
);

  if (DATA_W % NUM_LANES != 0) begin : g_bad_lanes
    $error("DATA_W must be a multiple of NUM_LANES");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("RD_LAT must be in 1..4");
  end

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [LANE_W-1:0]   mem [NUM_LANES][DEPTH];
  logic                in_range;
  logic                req;
  logic                acc_rd;
  logic                acc_wr;
  logic                bad;
  logic [DATA_W-1:0]   rd_row;
  logic [RD_LAT-1:0]   pv;
  logic [DATA_W-1:0]   pd [RD_LAT];

  assign in_range = {1'b0, address} < (ADDR_W+1)'(DEPTH);
  assign req      = req_ready & mem_en & (rd_req | wr_req);
  assign acc_rd   = req & in_range & rd_req;
  assign acc_wr   = req & in_range & wr_req;
  assign bad      = req & ~in_range;

  // Write-first: enabled lanes of a same-cycle write bypass the array.
  always_comb begin
    rd_row = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (acc_wr && wr_lane_en[i])
        rd_row[i*LANE_W +: LANE_W] = wr_data_in[i*LANE_W +: LANE_W];
      else if (in_range)
        rd_row[i*LANE_W +: LANE_W] = mem[i][address];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (state == CLEAR)
          mem[i][clr_cnt] <= '0;
        else if (acc_wr && wr_lane_en[i])
          mem[i][address] <= wr_data_in[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
      err_addr  <= 1'b0;
      pv        <= '0;
      for (int k = 0; k < RD_LAT; k++) pd[k] <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            clr_cnt   <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end
      endcase
      err_addr <= bad;
      // Data stages only load on valid so the tail holds the last read.
      pv[0] <= acc_rd;
      if (acc_rd) pd[0] <= rd_row;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  end

  assign rd_data_val = pv[RD_LAT-1];
  assign rd_data     = pd[RD_LAT-1];

endmodule

// File: tb/tb_sram_lane_ctrl.sv
// tb_sram_lane_ctrl: scoreboard bench for sram_lane_ctrl
// (32-bit rows, 2 lanes, 100 rows, read latency 2).
module tb_sram_lane_ctrl;

  localparam int DW  = 32;
  localparam int NL  = 2;
  localparam int DP  = 100;
  localparam int LAT = 2;
  localparam int AW  = 7;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 0;
  logic          rst_n;
  logic          mem_en;
  logic          rd_req;
  logic          wr_req;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data_in;
  logic [NL-1:0] wr_lane_en;
  logic          clear_req;
  logic          req_ready;
  logic          busy;
  logic          rd_data_val;
  logic [DW-1:0] rd_data;
  logic          err_addr;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  exp_t          q[$];
  exp_t          mon_e;
  logic [DW-1:0] mdl [DP];

  sram_lane_ctrl #(
    .DATA_W(DW), .NUM_LANES(NL), .DEPTH(DP), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en),
    .rd_req(rd_req), .wr_req(wr_req), .address(address),
    .wr_data_in(wr_data_in), .wr_lane_en(wr_lane_en),
    .clear_req(clear_req), .req_ready(req_ready), .busy(busy),
    .rd_data_val(rd_data_val), .rd_data(rd_data),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Read-return scoreboard: data and arrival cycle both checked.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL rd_missing due=%0d now=%0d", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (rd_data_val) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected got=%h want no valid", rd_data);
        end else begin
          mon_e = q.pop_front();
          if (rd_data !== mon_e.data || cyc != mon_e.due) begin
            bad++;
            $display("FAIL rd_data got=%h@%0d want=%h@%0d",
                     rd_data, cyc, mon_e.data, mon_e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en     = 0;
    rd_req     = 0;
    wr_req     = 0;
    clear_req  = 0;
    wr_lane_en = '0;
    wr_data_in = '0;
    address    = '0;
  endtask

  task automatic mdl_zero();
    for (int i = 0; i < DP; i++) mdl[i] = '0;
  endtask

  task automatic do_wr(input int a, input logic [DW-1:0] d,
                       input logic [NL-1:0] en);
    mem_en     = 1;
    wr_req     = 1;
    address    = AW'(a);
    wr_data_in = d;
    wr_lane_en = en;
    if (a < DP) begin
      if (en[0]) mdl[a][15:0]  = d[15:0];
      if (en[1]) mdl[a][31:16] = d[31:16];
    end
    tick();
    idle();
  endtask

  task automatic do_rd(input int a);
    mem_en  = 1;
    rd_req  = 1;
    address = AW'(a);
    q.push_back('{mdl[a], cyc + LAT});
    tick();
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
      q.delete();
    end
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (n != DP || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_cycles=%0d ready=%b want=%0d/1",
               nm, n, req_ready, DP);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) tick();
    total++;
    if ({busy, req_ready, rd_data_val, err_addr} !== 4'b1000 ||
        rd_data !== '0) begin
      bad++;
      $display("FAIL reset_state b/r/v/e=%b%b%b%b d=%h want 1000/0",
               busy, req_ready, rd_data_val, err_addr, rd_data);
    end
    rst_n = 1;
    count_busy("reset_clear");
    mdl_zero();
    do_rd(57);
    drain();
  endtask

  task automatic test_back_to_back();
    do_wr(3, 32'hDEADBEEF, 2'b11);
    do_rd(3);
    do_rd(4);
    do_rd(3);
    drain();
    total++;
    if (rd_data_val !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_hold v=%b d=%h want 0/deadbeef",
               rd_data_val, rd_data);
    end
  endtask

  task automatic test_lanes();
    do_wr(5, 32'h11112222, 2'b11);
    do_wr(5, 32'hAAAABBBB, 2'b10);
    do_rd(5);
    drain();
    do_wr(5, 32'h99998888, 2'b01);
    do_rd(5);
    do_wr(6, 32'h77776666, 2'b00);
    do_rd(6);
    drain();
  endtask

  task automatic test_rw_same();
    mem_en     = 1;
    rd_req     = 1;
    wr_req     = 1;
    address    = 7;
    wr_data_in = 32'h12345678;
    wr_lane_en = 2'b11;
    q.push_back('{32'h12345678, cyc + LAT});
    mdl[7] = 32'h12345678;
    tick();
    idle();
    drain();
  endtask

  task automatic test_err();
    do_wr(100, 32'hFFFFFFFF, 2'b11);
    total++;
    if (err_addr !== 1'b1) begin
      bad++;
      $display("FAIL err_pulse got=%b want=1", err_addr);
    end
    tick();
    total++;
    if (err_addr !== 1'b0) begin
      bad++;
      $display("FAIL err_width got=%b want=0", err_addr);
    end
    rd_req  = 1;
    mem_en  = 1;
    address = 127;
    tick();
    idle();
    total++;
    if (err_addr !== 1'b1) begin
      bad++;
      $display("FAIL err_rd got=%b want=1", err_addr);
    end
    mem_en     = 0;
    wr_req     = 1;
    address    = 120;
    tick();
    address    = 3;
    wr_data_in = 32'h0;
    wr_lane_en = 2'b11;
    tick();
    rd_req     = 1;
    wr_req     = 0;
    tick();
    idle();
    total++;
    if (err_addr !== 1'b0) begin
      bad++;
      $display("FAIL err_memen got=%b want=0", err_addr);
    end
    do_rd(3);
    do_rd(36);
    do_rd(0);
    do_rd(99);
    do_rd(5);
    do_rd(7);
    drain();
  endtask

  task automatic test_clear();
    int n = 0;
    do_wr(9, 32'hCAFEF00D, 2'b11);
    do_rd(9);
    clear_req = 1;
    tick();
    idle();
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_enter b=%b r=%b want 1/0", busy, req_ready);
    end
    while (busy && n < 300) begin
      mem_en     = (n == 10 || n == 20 || n == 30);
      wr_req     = (n == 10);
      rd_req     = (n == 20 || n == 30);
      address    = (n == 10) ? 11 : (n == 20) ? 110 : 9;
      wr_data_in = 32'h55555555;
      wr_lane_en = 2'b11;
      clear_req  = (n == 50);
      tick();
      idle();
      n++;
      if (n == 21) begin
        total++;
        if (err_addr !== 1'b0) begin
          bad++;
          $display("FAIL err_in_clear got=%b want=0", err_addr);
        end
      end
    end
    total++;
    if (n != DP) begin
      bad++;
      $display("FAIL clear_len got=%0d want=%0d", n, DP);
    end
    mdl_zero();
    do_rd(9);
    do_rd(11);
    drain();
  endtask

  task automatic test_reset_mid();
    do_wr(90, 32'h5A5A5A5A, 2'b11);
    do_rd(90);
    rst_n = 0;
    tick();
    q.delete();
    total++;
    if (rd_data_val !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_flush v=%b b=%b want 0/1", rd_data_val, busy);
    end
    tick();
    rst_n = 1;
    count_busy("rst_inflight");
    mdl_zero();
    do_wr(90, 32'h5A5A5A5A, 2'b11);
    clear_req = 1;
    tick();
    idle();
    repeat (40) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    count_busy("rst_mid_clear");
    mdl_zero();
    do_rd(90);
    do_rd(9);
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lanes();
    test_rw_same();
    test_err();
    test_clear();
    test_reset_mid();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_lane_ctrl.md
SRAM_LANE_CTRL -- requirements
Module: sram_lane_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning total row width in bits.
REQ-002 SHALL have parameter NUM_LANES, default 2, meaning number of equal-width internal banks per row.
REQ-003 SHALL have parameter DEPTH, default 100, meaning number of rows.
REQ-004 SHALL have parameter RD_LAT, default 1, meaning cycles from read accept to rd_data_val; legal 1..4.
REQ-005 SHALL have derived parameters ADDR_W = $clog2(DEPTH) and LANE_W = DATA_W/NUM_LANES.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port mem_en, input, 1, request qualifier; requests ignored when low.
REQ-009 SHALL have port rd_req, input, 1, read request.
REQ-010 SHALL have port wr_req, input, 1, write request.
REQ-011 SHALL have port address, input, ADDR_W, row address.
REQ-012 SHALL have port wr_data_in, input, DATA_W, write data; lane i = bits [i*LANE_W +: LANE_W].
REQ-013 SHALL have port wr_lane_en, input, NUM_LANES, per-lane write enable.
REQ-014 SHALL have port clear_req, input, 1, request to zero the whole memory.
REQ-015 SHALL have port req_ready, output, 1, high when requests are accepted.
REQ-016 SHALL have port busy, output, 1, high while clearing.
REQ-017 SHALL have port rd_data_val, output, 1, read data valid pulse.
REQ-018 SHALL have port rd_data, output, DATA_W, read data, same lane mapping as wr_data_in.
REQ-019 SHALL have port err_addr, output, 1, one-cycle pulse for an out-of-range request.

Function
REQ-020 SHALL contain NUM_LANES behavioural banks of DEPTH x LANE_W, all addressed by the same row address.
REQ-021 SHALL implement FSM states CLEAR and RUN; busy=1 and req_ready=0 in CLEAR; busy=0 and req_ready=1 in RUN.
REQ-022 In CLEAR, SHALL write zero to all lanes of row clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, then move to RUN; CLEAR lasts exactly DEPTH cycles.
REQ-023 In RUN, clear_req=1 SHALL move to CLEAR next cycle with clr_cnt=0; clear_req in CLEAR SHALL be ignored.
REQ-024 A request is accepted iff req_ready & mem_en & (rd_req|wr_req) & (address < DEPTH); a request presented while req_ready=0 SHALL be dropped with no error.
REQ-025 An accepted write SHALL update only lanes with wr_lane_en[i]=1; other lanes keep their content.
REQ-026 An accepted read SHALL raise rd_data_val for one cycle exactly RD_LAT cycles after the accept cycle; reads are fully pipelined, one per cycle.
REQ-027 rd_data SHALL hold its last valid value while rd_data_val=0.
REQ-028 A read accepted in the cycle after a write to the same row SHALL return the written data.
REQ-029 rd_req and wr_req both high on an accepted cycle SHALL perform the write and return post-write row content on the read (write-first).
REQ-030 address >= DEPTH with mem_en=1, req_ready=1 and rd_req|wr_req SHALL pulse err_addr for one cycle, RD_LAT-independent, on the following cycle; no memory access and no rd_data_val.
REQ-031 Reads in flight when entering CLEAR SHALL complete with the data captured at accept time.
REQ-032 Synthesis/elaboration SHALL fail if DATA_W % NUM_LANES != 0 or RD_LAT is outside 1..4.

Reset
REQ-033 rst_n=0 at a posedge SHALL set state=CLEAR, clr_cnt=0, busy=1, req_ready=0, rd_data_val=0, rd_data=0, err_addr=0, and flush the read pipeline.
REQ-034 Reset asserted mid-CLEAR or mid-read SHALL restart clearing from row 0 and drop all in-flight reads.

Verification (DATA_W=32, NUM_LANES=2, DEPTH=100, RD_LAT=2)
REQ-035 Release reset -> busy=1, req_ready=0 for exactly 100 cycles, then RUN; read row 57 -> rd_data_val 2 cycles later with 0x00000000.
REQ-036 Write 0xDEADBEEF row 3, wr_lane_en=2'b11; then back-to-back reads rows 3, 4, 3 -> rd_data_val on 3 consecutive cycles with 0xDEADBEEF, 0x00000000, 0xDEADBEEF.
REQ-037 Write 0x11112222 row 5, lanes 2'b11; write 0xAAAABBBB row 5, lanes 2'b10; read row 5 -> 0xAAAA2222.
REQ-038 rd_req=wr_req=1 row 7, data 0x12345678, lanes 2'b11 -> rd_data_val 2 cycles later with 0x12345678.
REQ-039 Write row 100 -> err_addr pulses next cycle, no rd_data_val, all rows unchanged; request with mem_en=0 -> no effect.
REQ-040 Write 0xCAFEF00D row 9, read row 9, clear_req the next cycle -> rd_data_val with 0xCAFEF00D, busy=1 for 100 cycles, then read row 9 -> 0x00000000; rst_n=0 at clear cycle 40 -> clear restarts, busy lasts 100 cycles after release.
